aes_round_ctrl: RTL and testbench

Iterative AES-128 encryption controller that drives the single-round datapath once per clock for all ten rounds. It accepts a plaintext/key pair over a valid/ready handshake and performs the initial AddRoundKey. It then sequences rounds 1–9 through the full round function and round 10 through the last-round function, while feeding round numbers 1–10 and the chained round key. It sits between the host/bus interface and the combinational round logic, and presents the ciphertext on an output valid/ready handshake.

---
 rtl/aes_pkg.sv | 105 ++++++++++
 rtl/aes_round_dp.sv | 33 +++
 rtl/aes_round_ctrl.sv | 103 ++++++++++
 tb/tb_aes_round_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared types, constants and AES-128 round helper functions.
// Byte order: byte 0 occupies the most significant byte of every 128-bit
// vector (the MSB of byte 0 is the vector MSB), matching FIPS-197 hex strings.
// Bytes are column-major: byte index = 4*column + row.
package aes_pkg;

    localparam int NR      = 10;
    localparam int BLOCK_W = 128;
    localparam int RN_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_LAST,
        ST_DONE
    } ctrl_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (a^254, which maps 0 to 0) followed by
    // the affine transform, avoiding a 256-entry table.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            inv = gmul(inv, inv);
            if (i != 0) inv = gmul(inv, a);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [RN_W-1:0] rn);
        logic [7:0] r;
        case (rn)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [BLOCK_W-1:0] key_expand(input logic [BLOCK_W-1:0] k,
                                                      input logic [RN_W-1:0]    rn);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
             ^ {rcon(rn), 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // SubBytes and ShiftRows fused: out[row][col] = S(in[row][(col+row)%4]).
    function automatic logic [BLOCK_W-1:0] sub_shift(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[BLOCK_W-1-8*(4*c+r) -: 8] = sbox(s[BLOCK_W-1-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [BLOCK_W-1:0] mix_columns(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[BLOCK_W-1-32*c -: 32];
            o[BLOCK_W-1-32*c -: 32] = {
                xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_round_dp.sv
// aes_round_dp: combinational single AES round.
//   state      : current cipher state
//   prkey      : previous round key; the round key for round rn is derived here
//   rn         : round number 1..10 (selects rcon)
//   last       : 1 = final round (MixColumns skipped)
//   next_state : round output
//   next_key   : round key used by this round, chained back by the controller
module aes_round_dp
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state,
    input  logic [BLOCK_W-1:0] prkey,
    input  logic [RN_W-1:0]    rn,
    input  logic               last,
    output logic [BLOCK_W-1:0] next_state,
    output logic [BLOCK_W-1:0] next_key
);

    logic [BLOCK_W-1:0] rkey;
    logic [BLOCK_W-1:0] ss;
    logic [BLOCK_W-1:0] full_out;
    logic [BLOCK_W-1:0] last_out;

    always_comb begin
        rkey       = key_expand(prkey, rn);
        ss         = sub_shift(state);
        full_out   = mix_columns(ss) ^ rkey;
        last_out   = ss ^ rkey;
        next_key   = rkey;
        next_state = last ? last_out : full_out;
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 encryption controller, one round per clock.
//   clk, rst              : clock, async active-high reset
//   in_valid / in_ready   : plaintext+key handshake (ready only in IDLE)
//   plaintext, key        : input block and cipher key
//   out_valid / out_ready : ciphertext handshake (valid only in DONE)
//   ciphertext            : always the state register; qualify with out_valid
//   busy                  : high in ROUND, LAST, DONE
//   round_num             : round number driven to the datapath (0 when idle/done)
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | waiting for a block; initial AddRoundKey on accept
// ROUND    | full rounds 1..9
// LAST     | round 10, no MixColumns
// DONE     | ciphertext held until out_ready
module aes_round_ctrl
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] plaintext,
    input  logic [BLOCK_W-1:0] key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] ciphertext,
    output logic               busy,
    output logic [RN_W-1:0]    round_num
);

    ctrl_state_e        fsm_q, fsm_d;
    logic [BLOCK_W-1:0] state_q, state_d;
    logic [BLOCK_W-1:0] key_q, key_d;
    logic [RN_W-1:0]    rn_q, rn_d;
    logic [BLOCK_W-1:0] dp_state;
    logic [BLOCK_W-1:0] dp_key;

    aes_round_dp u_dp (
        .state      (state_q),
        .prkey      (key_q),
        .rn         (rn_q),
        .last       (fsm_q == ST_LAST),
        .next_state (dp_state),
        .next_key   (dp_key)
    );

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        rn_d    = rn_q;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = plaintext ^ key;
                    key_d   = key;
                    rn_d    = 4'd1;
                    fsm_d   = ST_ROUND;
                end
            end
            ST_ROUND: begin
                state_d = dp_state;
                key_d   = dp_key;
                rn_d    = rn_q + 4'd1;
                if (rn_q == RN_W'(NR - 1)) fsm_d = ST_LAST;
            end
            ST_LAST: begin
                state_d = dp_state;
                key_d   = dp_key;
                rn_d    = 4'd0;
                fsm_d   = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) fsm_d = ST_IDLE;
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            key_q   <= '0;
            rn_q    <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            rn_q    <= rn_d;
        end
    end

    // Handshake outputs decode the state register only, so out_ready has no
    // combinational path to in_ready.
    assign in_ready   = (fsm_q == ST_IDLE);
    assign out_valid  = (fsm_q == ST_DONE);
    assign busy       = (fsm_q != ST_IDLE);
    assign round_num  = rn_q;
    assign ciphertext = state_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
module tb_aes_round_ctrl;
    import aes_pkg::*;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] plaintext = '0;
    logic [127:0] key = '0;
    logic         in_ready, out_valid, busy;
    logic [127:0] ciphertext;
    logic [3:0]   round_num;

    aes_round_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy),
        .round_num  (round_num)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    int n_out = 0;
    bit lat_en = 1'b1;

    typedef struct {
        logic [127:0] ct;
        int           acc;
        bit           chk_lat;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired (t=%0t)", nm, $time);
    endtask

    // Stimulus moves at negedge+1; monitors sample at negedge+2, so both see
    // the values present at the following rising edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Scoreboard: input side pushes the hand-computed ciphertext at each accept,
    // output side pops and compares at each output handshake.
    always begin : mon
        exp_t e;
        @(negedge clk);
        #2;
        if (!rst) begin
            if (in_valid && in_ready) begin
                if (plaintext == C1_PT && key == C1_KEY) e.ct = C1_CT;
                else if (plaintext == B_PT && key == B_KEY) e.ct = B_CT;
                else begin
                    e.ct = 'x;
                    n_cmp++;
                    n_err++;
                    $display("FAIL unknown_vector accepted: pt %h key %h", plaintext, key);
                end
                e.acc     = cyc + 1;
                e.chk_lat = lat_en;
                sb.push_back(e);
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got %h expected none", ciphertext);
                end else begin
                    e = sb.pop_front();
                    chk("ciphertext", ciphertext, e.ct);
                    if (e.chk_lat) chki("out_latency", cyc + 1 - e.acc, 11);
                end
            end
        end
    end

    task automatic send(input logic [127:0] pt, input logic [127:0] k, output int acc);
        int n;
        n = 0;
        plaintext = pt;
        key       = k;
        in_valid  = 1'b1;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            fail_now("accept_timeout");
            acc = -1;
        end else begin
            acc = cyc + 1;
        end
        tick();
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!(sb.size() == 0 && in_ready) && n < 300) begin
            tick();
            n++;
        end
        if (!(sb.size() == 0 && in_ready)) fail_now("completion_timeout");
    endtask

    initial begin
        int a1, a2, n;

        // Reset state
        tick();
        tick();
        chki("rst_in_ready", int'(in_ready), 1);
        chki("rst_out_valid", int'(out_valid), 0);
        chki("rst_busy", int'(busy), 0);
        chki("rst_round_num", int'(round_num), 0);
        chk("rst_ciphertext", ciphertext, '0);
        rst = 1'b0;
        tick();

        // C.1 with out_ready high (latency checked by the monitor)
        out_ready = 1'b1;
        send(C1_PT, C1_KEY, a1);
        in_valid = 1'b0;
        wait_done();

        // Appendix B: round_num steps 1..10 on consecutive cycles
        send(B_PT, B_KEY, a1);
        in_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            chki("round_num_step", int'(round_num), i);
            chki("busy_in_round", int'(busy), 1);
            tick();
        end
        chki("done_out_valid", int'(out_valid), 1);
        chki("done_round_num", int'(round_num), 0);
        wait_done();

        // Backpressure: hold DONE for 20 cycles
        out_ready = 1'b0;
        lat_en    = 1'b0;
        send(C1_PT, C1_KEY, a1);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        if (!out_valid) fail_now("bp_out_valid_timeout");
        for (int i = 0; i < 20; i++) begin
            chki("bp_out_valid", int'(out_valid), 1);
            chki("bp_in_ready", int'(in_ready), 0);
            chk("bp_ciphertext", ciphertext, C1_CT);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chki("bp_release_in_ready", int'(in_ready), 1);
        chki("bp_release_out_valid", int'(out_valid), 0);
        lat_en = 1'b1;
        wait_done();

        // Back-to-back: in_valid held high across two blocks
        send(B_PT, B_KEY, a1);
        plaintext = C1_PT;
        key       = C1_KEY;
        send(C1_PT, C1_KEY, a2);
        in_valid = 1'b0;
        chki("b2b_accept_gap", a2 - a1, 12);
        wait_done();

        // Input churn during ROUND is ignored
        send(C1_PT, C1_KEY, a1);
        for (int i = 0; i < 4; i++) begin
            plaintext = {$urandom, $urandom, $urandom, $urandom};
            key       = {$urandom, $urandom, $urandom, $urandom};
            in_valid  = ~in_valid;
            chki("churn_in_ready", int'(in_ready), 0);
            tick();
        end
        in_valid = 1'b0;
        wait_done();

        // Reset in round 5, then a clean C.1 run
        send(C1_PT, C1_KEY, a1);
        in_valid = 1'b0;
        n = 0;
        while (round_num != 4'd5 && n < 20) begin
            tick();
            n++;
        end
        if (round_num != 4'd5) fail_now("round5_timeout");
        #1;
        rst = 1'b1;
        #1;
        chki("mid_rst_in_ready", int'(in_ready), 1);
        chki("mid_rst_out_valid", int'(out_valid), 0);
        chki("mid_rst_busy", int'(busy), 0);
        chki("mid_rst_round_num", int'(round_num), 0);
        chk("mid_rst_ciphertext", ciphertext, '0);
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        send(C1_PT, C1_KEY, a1);
        in_valid = 1'b0;
        wait_done();

        tick();
        chki("output_count", n_out, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
